// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls two SNES-style shift-register game pads over a shared
// latch/clock pair and presents parallel active-high button words.
//
// Optional feature macro: PAD_DEBOUNCE_EN
//   defined   - an output bit changes only when two consecutive polls agree
//   undefined - outputs take each poll's words directly
//
// Ports:
//   clock         system clock (single domain)
//   reset         synchronous, active-high
//   pad_data_p1   serial data from controller 1, active-low (0 = pressed)
//   pad_data_p2   serial data from controller 2, active-low
//   pad_latch     shared latch to both controllers
//   pad_clk       shared shift clock, idles high
//   p1_buttons    controller 1 word, 1 = pressed, bit k = k-th serial bit
//   p2_buttons    controller 2 word, same encoding
//   sample_valid  one-cycle pulse in the cycle the button words update
module snes_pad_reader #(
   parameter int unsigned HALF     = 150,
   parameter int unsigned POLL_DIV = 833333,
   parameter int unsigned BITS     = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            pad_data_p1,
   input  logic            pad_data_p2,
   output logic            pad_latch,
   output logic            pad_clk,
   output logic [BITS-1:0] p1_buttons,
   output logic [BITS-1:0] p2_buttons,
   output logic            sample_valid
);

   localparam int unsigned CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int unsigned TMR_W = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
   localparam int unsigned BIT_W = (BITS > 1) ? $clog2(BITS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      READ,
      UPDATE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  poll_cnt;
   logic              poll_req;
   logic [TMR_W-1:0]  timer;
   logic [BIT_W-1:0]  bit_idx;
   logic              p1_meta, p1_sync;
   logic              p2_meta, p2_sync;
   logic [BITS-1:0]   shadow_p1, shadow_p2;
`ifdef PAD_DEBOUNCE_EN
   logic [BITS-1:0]   prev_p1, prev_p2;
   logic [BITS-1:0]   agree_p1, agree_p2;
`endif

   // Two-flop synchronizers for the asynchronous pad data lines.
   always_ff @(posedge clock) begin
      if (reset) begin
         p1_meta <= 1'b1;
         p1_sync <= 1'b1;
         p2_meta <= 1'b1;
         p2_sync <= 1'b1;
      end else begin
         p1_meta <= pad_data_p1;
         p1_sync <= p1_meta;
         p2_meta <= pad_data_p2;
         p2_sync <= p2_meta;
      end
   end

   // Free-running poll divider; requests arriving outside IDLE are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         poll_cnt <= '0;
      end else if (poll_cnt == CNT_W'(POLL_DIV - 1)) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + CNT_W'(1);
      end
   end

   assign poll_req = (poll_cnt == CNT_W'(POLL_DIV - 1));

`ifdef PAD_DEBOUNCE_EN
   // Bits on which this poll and the previous poll agree.
   assign agree_p1 = ~(shadow_p1 ^ prev_p1);
   assign agree_p2 = ~(shadow_p2 ^ prev_p2);
`endif

   // Poll sequencer. The commit happens on the edge entering UPDATE so that
   // the new words and sample_valid are both visible during the UPDATE cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         pad_latch    <= 1'b0;
         pad_clk      <= 1'b1;
         timer        <= '0;
         bit_idx      <= '0;
         shadow_p1    <= '0;
         shadow_p2    <= '0;
         p1_buttons   <= '0;
         p2_buttons   <= '0;
         sample_valid <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
         prev_p1      <= '0;
         prev_p2      <= '0;
`endif
      end else begin
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               pad_latch <= 1'b0;
               pad_clk   <= 1'b1;
               if (poll_req) begin
                  state     <= LATCH;
                  pad_latch <= 1'b1;
                  timer     <= '0;
                  shadow_p1 <= '0;
                  shadow_p2 <= '0;
               end
            end

            LATCH: begin
               if (timer == TMR_W'(2 * HALF - 1)) begin
                  state     <= READ;
                  pad_latch <= 1'b0;
                  pad_clk   <= 1'b0;
                  timer     <= '0;
                  bit_idx   <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            READ: begin
               timer <= timer + TMR_W'(1);
               // Last low-phase cycle: capture the bit and raise pad_clk.
               if (timer == TMR_W'(HALF - 1)) begin
                  shadow_p1[bit_idx] <= ~p1_sync;
                  shadow_p2[bit_idx] <= ~p2_sync;
                  pad_clk            <= 1'b1;
               end
               // End of high phase: next bit, or finish the frame.
               if (timer == TMR_W'(2 * HALF - 1)) begin
                  timer <= '0;
                  if (bit_idx == BIT_W'(BITS - 1)) begin
                     state        <= UPDATE;
                     sample_valid <= 1'b1;
`ifdef PAD_DEBOUNCE_EN
                     p1_buttons <= (shadow_p1 & agree_p1) | (p1_buttons & ~agree_p1);
                     p2_buttons <= (shadow_p2 & agree_p2) | (p2_buttons & ~agree_p2);
                     prev_p1    <= shadow_p1;
                     prev_p2    <= shadow_p2;
`else
                     p1_buttons <= shadow_p1;
                     p2_buttons <= shadow_p2;
`endif
                  end else begin
                     bit_idx <= bit_idx + BIT_W'(1);
                     pad_clk <= 1'b0;
                  end
               end
            end

            UPDATE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
